// File: rtl/parity_serial_rx.sv
// Receiver for the parity-protected serial link: deserialises start/data/parity/stop frames,
// reports parity and framing status per word and keeps a saturating error count.
module parity_serial_rx #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned ODD       = 0,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 err_clear,
    output logic [WIDTH-1:0]     data,
    output logic                 data_valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] err_count
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] ErrMax = '1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    state_e               state_q, state_d;
    logic                 busy_q;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]     shift_q, shift_d;
    logic                 par_q, par_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic                 dv_q, dv_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic [CNT_WIDTH-1:0] errc_q, errc_d;

    logic stop_take;
    logic exp_par;
    logic perr_now;
    logic ferr_now;

    // State register; busy is registered alongside so it tracks the state exactly.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d != StIdle);
        end
    end

    always_comb begin
        state_d = state_q;
        if (bit_valid) begin
            case (state_q)
                StIdle:   if (!bit_in) state_d = StData;
                StData:   if (cnt_q == LastBit) state_d = StParity;
                StParity: state_d = StStop;
                StStop:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    assign stop_take = bit_valid && (state_q == StStop);
    assign exp_par   = (^shift_q) ^ (ODD != 0);
    assign perr_now  = (par_q != exp_par);
    assign ferr_now  = !bit_in;

    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        par_d   = par_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        if (bit_valid) begin
            case (state_q)
                StIdle:   cnt_d = '0;
                StData: begin
                    // LSB-first: each new bit enters at the top and walks down.
                    shift_d = (shift_q >> 1) | (WIDTH'(bit_in) << (WIDTH - 1));
                    cnt_d   = cnt_q + CntW'(1);
                end
                StParity: par_d = bit_in;
                StStop: begin
                    data_d = shift_q;
                    perr_d = perr_now;
                    ferr_d = ferr_now;
                    dv_d   = 1'b1;
                end
                default: ;
            endcase
        end

        errc_d = errc_q;
        if (err_clear) begin
            errc_d = '0;
        end else if (stop_take && (perr_now || ferr_now) && (errc_q != ErrMax)) begin
            errc_d = errc_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            errc_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            errc_q  <= errc_d;
        end
    end

    assign data       = data_q;
    assign data_valid = dv_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = busy_q;
    assign err_count  = errc_q;

endmodule

// File: tb/tb_parity_serial_rx.sv
// Scoreboard bench: drives even- and odd-parity receivers with the same directed frames and
// checks every delivered word against queued expectations.
module tb_parity_serial_rx;

    logic clock = 1'b0;
    logic reset;
    logic bit_valid;
    logic bit_in;
    logic err_clear;

    logic [3:0] data_e, data_o;
    logic       dv_e, dv_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;
    logic [1:0] cnt_e, cnt_o;

    parity_serial_rx #(.WIDTH(4), .ODD(0), .CNT_WIDTH(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .err_clear  (err_clear),
        .data       (data_e),
        .data_valid (dv_e),
        .parity_err (perr_e),
        .frame_err  (ferr_e),
        .busy       (busy_e),
        .err_count  (cnt_e)
    );

    parity_serial_rx #(.WIDTH(4), .ODD(1), .CNT_WIDTH(2)) dut_odd (
        .clock      (clock),
        .reset      (reset),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .err_clear  (err_clear),
        .data       (data_o),
        .data_valid (dv_o),
        .parity_err (perr_o),
        .frame_err  (ferr_o),
        .busy       (busy_o),
        .err_count  (cnt_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] data;
        logic       perr_e;
        logic       perr_o;
        logic       ferr;
        logic [1:0] cnt_e;
        logic [1:0] cnt_o;
    } exp_t;

    exp_t       sb_q[$];
    int         checks = 0;
    int         errors = 0;
    int         busy_cnt = 0;
    logic [1:0] mcnt_e = 2'd0;
    logic [1:0] mcnt_o = 2'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every data_valid cycle consumes exactly one expectation.
    always @(negedge clock) begin
        if (busy_e) busy_cnt++;
        if (reset && (dv_e || dv_o)) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_data_valid: got dv_e=%0b dv_o=%0b expected none",
                         dv_e, dv_o);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("dv_even", 32'(dv_e), 32'd1);
                check("dv_odd", 32'(dv_o), 32'd1);
                check("data_even", 32'(data_e), 32'(e.data));
                check("data_odd", 32'(data_o), 32'(e.data));
                check("perr_even", 32'(perr_e), 32'(e.perr_e));
                check("perr_odd", 32'(perr_o), 32'(e.perr_o));
                check("ferr_even", 32'(ferr_e), 32'(e.ferr));
                check("ferr_odd", 32'(ferr_o), 32'(e.ferr));
                check("errcnt_even", 32'(cnt_e), 32'(e.cnt_e));
                check("errcnt_odd", 32'(cnt_o), 32'(e.cnt_o));
            end
        end
    end

    task automatic drive(input logic v, input logic b, input logic clr);
        @(posedge clock);
        #1;
        bit_valid = v;
        bit_in    = b;
        err_clear = clr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, 1'b0);
    endtask

    function automatic logic [1:0] next_cnt(input logic [1:0] c, input logic err, input bit clr);
        if (clr) return 2'd0;
        if (err && c != 2'd3) return c + 2'd1;
        return c;
    endfunction

    // Frame: start, d[0..3], parity, stop. gap inserts a bit_valid=0 cycle with junk bit_in.
    task automatic send_frame(input logic [3:0] d, input logic p, input logic s,
                              input logic pe, input logic po, input logic fe,
                              input bit gap, input bit clr);
        logic [6:0] bits;
        exp_t e;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < 7; i++) begin
            if (i == 6) begin
                mcnt_e = next_cnt(mcnt_e, pe | fe, clr);
                mcnt_o = next_cnt(mcnt_o, po | fe, clr);
                e.data = d; e.perr_e = pe; e.perr_o = po; e.ferr = fe;
                e.cnt_e = mcnt_e; e.cnt_o = mcnt_o;
                sb_q.push_back(e);
            end
            drive(1'b1, bits[i], (i == 6) && clr);
            if (gap) drive(1'b0, ~bits[i], 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, 32'(data_e), 32'd0);
        check({tag, "_dv"}, 32'(dv_e), 32'd0);
        check({tag, "_perr"}, 32'(perr_e), 32'd0);
        check({tag, "_ferr"}, 32'(ferr_e), 32'd0);
        check({tag, "_busy"}, 32'(busy_e), 32'd0);
        check({tag, "_errcnt"}, 32'(cnt_e), 32'd0);
        check({tag, "_busy_odd"}, 32'(busy_o), 32'd0);
        check({tag, "_errcnt_odd"}, 32'(cnt_o), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        bit_valid = 1'b0;
        bit_in    = 1'b1;
        err_clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b1;
        idle(2);

        // 1: clean 4'hB, parity 1; odd receiver flags it. busy for 6 cycles.
        busy_cnt = 0;
        send_frame(4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("busy_cycles", 32'(busy_cnt), 32'd6);

        // 2: parity 0 -> even error, odd accepts.
        send_frame(4'hB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // 3: framing error, then back-to-back clean 4'h5.
        send_frame(4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_frame(4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // 4: four bad frames saturate, fifth with err_clear on its stop bit.
        for (int i = 0; i < 4; i++)
            send_frame(4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("sat_even", 32'(cnt_e), 32'd3);
        check("sat_odd", 32'(cnt_o), 32'd3);
        send_frame(4'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(2);
        check("clr_even", 32'(cnt_e), 32'd0);

        // 5: frame 1 with bit_valid toggling.
        send_frame(4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(3);

        // 6: reset mid-DATA, then clean 4'h5 and the odd-parity acceptance of 4'hB.
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check_zero("midreset");
        mcnt_e = 2'd0;
        mcnt_o = 2'd0;
        idle(1);
        reset = 1'b1;
        idle(2);
        send_frame(4'h5, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        send_frame(4'hB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(3);

        for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clock);
        check("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
